mii_rx: RTL and testbench
=========================

MII_RX -- requirements
Module: mii_rx

Interface
REQ-001 SHALL have parameter MAC_ADDR, 48'h0, station address accepted by the destination filter.
REQ-002 SHALL have parameter MAX_LEN, 1518, maximum frame bytes from destination through FCS.
REQ-003 SHALL have port clk, input, 1, the single clock: MII receive clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port rxd, input, 4, receive nibble, low nibble of each byte first.
REQ-006 SHALL have port rx_dv, input, 1, receive data valid.
REQ-007 SHALL have port rx_er, input, 1, receive error.
REQ-008 SHALL have port mac_src, output, 48, source MAC of the current accepted frame.
REQ-009 SHALL have port ethertype, output, 16, ethertype of the current accepted frame.
REQ-010 SHALL have port hdr_valid, output, 1, one-cycle pulse when mac_src and ethertype are valid.
REQ-011 SHALL have port dout, output, 8, payload byte.
REQ-012 SHALL have port dout_valid, output, 1, qualifies dout; no backpressure.
REQ-013 SHALL have port dout_last, output, 1, marks the final payload byte.
REQ-014 SHALL have port frame_done, output, 1, one-cycle end-of-frame status pulse.
REQ-015 SHALL have port frame_ok, output, 1, valid with frame_done; high only if no error flag is set.
REQ-016 SHALL have port err, output, 4, valid with frame_done: {crc_bad, runt, oversize, phy_err}.

Function
REQ-017 FSM SHALL have states IDLE, PREAMBLE, HEADER, PAYLOAD and DROP.
REQ-018 IDLE SHALL go to PREAMBLE on rx_dv=1 with rxd=4'h5.
REQ-019 PREAMBLE SHALL go to HEADER on rxd=4'hD after at least one 4'h5.
REQ-020 In PREAMBLE, any other nibble or rx_dv=0 SHALL return the FSM to IDLE, with no outputs.
REQ-021 Bytes SHALL assemble as {second nibble, first nibble}; a byte completes on its second nibble.
REQ-022 A 12-bit byte counter SHALL count dest..FCS and saturate at 4095.
REQ-023 HEADER SHALL capture bytes 0-5 as dest, 6-11 as mac_src and 12-13 as ethertype, each first byte most significant.
REQ-024 After byte 5, the FSM SHALL go to DROP when dest is neither MAC_ADDR nor 48'hFFFFFFFFFFFF.
REQ-025 A dropped frame SHALL produce no hdr_valid, dout_valid or frame_done.
REQ-026 hdr_valid SHALL pulse on the cycle after byte 13 completes; the FSM then enters PAYLOAD.
REQ-027 PAYLOAD bytes SHALL pass through a 5-byte delay line.
REQ-028 dout_valid SHALL pulse, emitting the oldest byte, when a new byte completes and the line is full, so FCS bytes are never emitted.
REQ-029 The cycle after rx_dv falls in PAYLOAD, the oldest byte SHALL be emitted with dout_last=1.
REQ-030 frame_done SHALL pulse in the same cycle as dout_last; the FSM then returns to IDLE.
REQ-031 If the delay line is not full when rx_dv falls, frame_done SHALL pulse with runt set and no dout_last.
REQ-032 CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) SHALL cover dest..FCS.
REQ-033 crc_bad SHALL be set when the residue is not 32'hC704DD7B or an odd nibble count is received.
REQ-034 runt SHALL be set when the count is below 64.
REQ-035 On rx_er=1 in HEADER/PAYLOAD, phy_err SHALL be set; the frame continues to the end.
REQ-036 When the count exceeds MAX_LEN, oversize SHALL be set and output SHALL stop.
REQ-037 After an oversize, frame_done SHALL pulse the cycle after rx_dv falls, with no dout_last.
REQ-038 IDLE SHALL be re-entered directly from DROP when rx_dv=0.
REQ-039 rx_dv low for one cycle in the IDLE state SHALL suffice before a new preamble is accepted.

Reset
REQ-040 While rst=0, the FSM SHALL be IDLE.
REQ-041 While rst=0, every output, counter, CRC register and the delay line SHALL be zero, except the CRC register, which SHALL be FFFFFFFF.
REQ-042 Reset asserted mid-frame SHALL abort the frame with no frame_done, both at assertion and after release.
REQ-043 After release, reception SHALL restart only on a fresh preamble.

Structure
REQ-044 Package eth_pkg SHALL hold the FSM state enum and PREAMBLE_NIB=4'h5 / SFD_NIB=4'hD.
REQ-045 eth_pkg SHALL also hold BROADCAST, CRC_POLY, CRC_RESIDUE, MIN_LEN=64 and HDR_LEN=14.
REQ-046 The byte-wise CRC update SHALL be sub-module crc32_d8 (8-bit data, 32-bit state), shared with the transmit path.

Verification
REQ-047 Scenario: 7x5+D preamble, dest=MAC_ADDR, 46-byte payload 00..2D, good FCS.
Required response: hdr_valid once, 46 dout bytes 00..2D, dout_last on 2D, frame_done with frame_ok=1 and err=0.
REQ-048 Scenario: broadcast dest, 50-byte payload, FCS last byte flipped.
Required response: 50 bytes output, frame_done with err=4'b1000.
REQ-049 Scenario: dest=02:00:00:00:00:01 not matching MAC_ADDR.
Required response: no hdr_valid, dout_valid or frame_done.
REQ-050 Scenario: 40-byte total frame with good CRC.
Required response: frame_done with runt set and frame_ok=0.
REQ-051 Scenario: rx_er pulse at payload byte 10, then a MAX_LEN+1 frame.
Required response: first frame err=4'b0001; second frame err has oversize set and output stops after byte MAX_LEN-19.
REQ-052 Scenario: rst low mid-payload, then released and a good frame sent.
Required response: no frame_done for the aborted frame; second frame frame_ok=1.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet receive constants, state type and CRC helper
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DROP
    } rx_state_t;

    localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  SFD_NIB      = 4'hD;
    localparam logic [47:0] BROADCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam int          MIN_LEN      = 64;
    localparam int          HDR_LEN      = 14;
    localparam int          DLY_LEN      = 5;

    // The CRC register shifts LSB first, so polynomial and residue are used bit-reversed.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - one-byte reflected CRC-32 update, shared by receive and transmit paths
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    localparam logic [31:0] POLY_REF = bitrev32(CRC_POLY);

    logic [31:0] c;

    // Eight LSB-first shift steps, data bit 0 enters first.
    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ ({32{c[0] ^ data[i]}} & POLY_REF);
        end
        crc_next = c;
    end

endmodule

// File: rtl/mii_rx.sv
// rtl/mii_rx.sv - MII receive: preamble strip, address filter, header extract, payload out, FCS check
module mii_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter int          MAX_LEN  = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [47:0] mac_src,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic        dout_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [3:0]  err
);

    localparam logic [31:0] RES_REF = bitrev32(CRC_RESIDUE);

    rx_state_t state, state_next;

    logic                  armed;
    logic                  phase;
    logic [3:0]            lo_nib;
    logic [11:0]           cnt;
    logic [39:0]           dest_sr;
    logic [47:0]           src_sr;
    logic [7:0]            type_hi;
    logic [DLY_LEN-1:0][7:0] dl;
    logic [2:0]            dl_cnt;
    logic [31:0]           crc_reg;
    logic [31:0]           crc_next;
    logic                  phy_f;
    logic                  ovs_f;

    logic        in_frame;
    logic        byte_stb;
    logic [7:0]  byte_val;
    logic [47:0] dest_full;
    logic        dest_ok;
    logic        hdr_end;
    logic        over_now;
    logic        frame_end;
    logic        line_full;
    logic [3:0]  err_end;

    crc32_d8 u_crc (
        .crc      (crc_reg),
        .data     (byte_val),
        .crc_next (crc_next)
    );

    // Byte assembly strobes and end-of-frame status terms.
    always_comb begin
        in_frame  = (state == HEADER) || (state == PAYLOAD);
        byte_stb  = in_frame && rx_dv && phase;
        byte_val  = {rxd, lo_nib};
        dest_full = {dest_sr, byte_val};
        dest_ok   = (dest_full == MAC_ADDR) || (dest_full == BROADCAST);
        hdr_end   = byte_stb && (cnt == 12'(HDR_LEN - 1));
        over_now  = byte_stb && (cnt >= 12'(MAX_LEN));
        frame_end = in_frame && !rx_dv;
        line_full = (dl_cnt == 3'(DLY_LEN));
        err_end   = {(crc_reg != RES_REF) || phase,
                     (cnt < 12'(MIN_LEN)) || !line_full,
                     ovs_f,
                     phy_f || rx_er};
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a preamble is only accepted after the line has been idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (armed && rx_dv && (rxd == PREAMBLE_NIB)) state_next = PREAMBLE;
            end
            PREAMBLE: begin
                if (!rx_dv)                     state_next = IDLE;
                else if (rxd == SFD_NIB)        state_next = HEADER;
                else if (rxd != PREAMBLE_NIB)   state_next = IDLE;
            end
            HEADER: begin
                if (!rx_dv)                                       state_next = IDLE;
                else if (byte_stb && (cnt == 12'd5) && !dest_ok)  state_next = DROP;
                else if (hdr_end)                                 state_next = PAYLOAD;
            end
            PAYLOAD: begin
                if (!rx_dv) state_next = IDLE;
            end
            DROP: begin
                if (!rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: nibble pairing, header capture, delay line, CRC and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed      <= 1'b0;
            phase      <= 1'b0;
            lo_nib     <= '0;
            cnt        <= '0;
            dest_sr    <= '0;
            src_sr     <= '0;
            type_hi    <= '0;
            dl         <= '0;
            dl_cnt     <= '0;
            crc_reg    <= CRC_INIT;
            phy_f      <= 1'b0;
            ovs_f      <= 1'b0;
            mac_src    <= '0;
            ethertype  <= '0;
            hdr_valid  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err        <= '0;
        end else begin
            hdr_valid  <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err        <= '0;

            if (state == IDLE) begin
                if (!rx_dv) armed <= 1'b1;
            end else begin
                armed <= 1'b0;
            end

            if ((state == PREAMBLE) && rx_dv && (rxd == SFD_NIB)) begin
                phase   <= 1'b0;
                cnt     <= '0;
                dl_cnt  <= '0;
                crc_reg <= CRC_INIT;
                phy_f   <= 1'b0;
                ovs_f   <= 1'b0;
            end

            if (in_frame && rx_dv) begin
                if (rx_er) phy_f <= 1'b1;
                phase <= ~phase;
                if (!phase) lo_nib <= rxd;
            end

            if (byte_stb) begin
                crc_reg <= crc_next;
                if (cnt != 12'hFFF) cnt <= cnt + 12'd1;

                if (state == HEADER) begin
                    if (cnt < 12'd6)       dest_sr <= dest_full[39:0];
                    else if (cnt < 12'd12) src_sr  <= {src_sr[39:0], byte_val};
                    else if (cnt == 12'd12) type_hi <= byte_val;
                    if (hdr_end) begin
                        hdr_valid <= 1'b1;
                        mac_src   <= src_sr;
                        ethertype <= {type_hi, byte_val};
                    end
                end

                if (state == PAYLOAD) begin
                    if (over_now) begin
                        ovs_f <= 1'b1;
                    end else if (!ovs_f) begin
                        dl <= {dl[DLY_LEN-2:0], byte_val};
                        if (line_full) begin
                            dout       <= dl[DLY_LEN-1];
                            dout_valid <= 1'b1;
                        end else begin
                            dl_cnt <= dl_cnt + 3'd1;
                        end
                    end
                end
            end

            // A frame that ends before the address is known is discarded silently.
            if (frame_end && ((state == PAYLOAD) || (cnt >= 12'd6))) begin
                frame_done <= 1'b1;
                err        <= err_end;
                frame_ok   <= (err_end == 4'b0000);
                if ((state == PAYLOAD) && !ovs_f && line_full) begin
                    dout       <= dl[DLY_LEN-1];
                    dout_valid <= 1'b1;
                    dout_last  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mii_rx.sv
// tb/tb_mii_rx.sv - scoreboard bench for mii_rx
module tb_mii_rx;

    localparam logic [47:0] MAC  = 48'h02_00_00_00_00_AA;
    localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC  = 48'h00_11_22_33_44_55;
    localparam int          MAXL = 1518;

    logic        clk;
    logic        rst;
    logic [3:0]  rxd;
    logic        rx_dv;
    logic        rx_er;
    logic [47:0] mac_src;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_last;
    logic        frame_done;
    logic        frame_ok;
    logic [3:0]  err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fq[$];
    logic [8:0]  exp_data[$];
    logic [63:0] exp_hdr[$];
    logic [4:0]  exp_frame[$];

    mii_rx #(.MAC_ADDR(MAC), .MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .mac_src    (mac_src),
        .ethertype  (ethertype),
        .hdr_valid  (hdr_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                         input int plen, input logic [7:0] base);
        logic [31:0] c;
        fq.delete();
        for (int i = 5; i >= 0; i--) fq.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fq.push_back(src[i*8 +: 8]);
        fq.push_back(et[15:8]);
        fq.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) fq.push_back(8'(base + 8'(i)));
        c = 32'hFFFF_FFFF;
        foreach (fq[i]) c = crc_byte(c, fq[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) fq.push_back(c[i*8 +: 8]);
    endtask

    task automatic expect_out(input int nbytes, input bit with_last, input bit with_done,
                              input logic ok, input logic [3:0] e, input logic [15:0] et);
        exp_hdr.push_back({SRC, et});
        for (int i = 0; i < nbytes; i++)
            exp_data.push_back({(with_last && (i == nbytes - 1)), fq[14 + i]});
        if (with_done) exp_frame.push_back({ok, e});
    endtask

    task automatic nib(input logic [3:0] d, input logic dv, input logic er);
        rxd   = d;
        rx_dv = dv;
        rx_er = er;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pre();
        repeat (15) nib(4'h5, 1'b1, 1'b0);
        nib(4'hD, 1'b1, 1'b0);
    endtask

    task automatic send_bytes(input int from, input int to, input int er_idx);
        logic [7:0] b;
        for (int i = from; i < to; i++) begin
            b = fq[i];
            nib(b[3:0], 1'b1, i == er_idx);
            nib(b[7:4], 1'b1, i == er_idx);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) nib(4'h0, 1'b0, 1'b0);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_data_left"},  64'(exp_data.size()),  64'd0);
        check({tag, "_hdr_left"},   64'(exp_hdr.size()),   64'd0);
        check({tag, "_frame_left"}, 64'(exp_frame.size()), 64'd0);
    endtask

    task automatic monitor();
        logic [8:0]  d;
        logic [63:0] h;
        logic [4:0]  f;
        forever begin
            @(negedge clk);
            if (dout_valid) begin
                if (exp_data.size() == 0) begin
                    check("dout_unexpected", 64'(dout_valid), 64'd0);
                end else begin
                    d = exp_data.pop_front();
                    check("dout", 64'(dout), 64'(d[7:0]));
                    check("dout_last", 64'(dout_last), 64'(d[8]));
                end
            end else if (dout_last) begin
                check("dout_last_no_valid", 64'(dout_last), 64'd0);
            end
            if (hdr_valid) begin
                if (exp_hdr.size() == 0) begin
                    check("hdr_unexpected", 64'(hdr_valid), 64'd0);
                end else begin
                    h = exp_hdr.pop_front();
                    check("mac_src", 64'(mac_src), 64'(h[63:16]));
                    check("ethertype", 64'(ethertype), 64'(h[15:0]));
                end
            end
            if (frame_done) begin
                if (exp_frame.size() == 0) begin
                    check("done_unexpected", 64'(frame_done), 64'd0);
                end else begin
                    f = exp_frame.pop_front();
                    check("frame_ok", 64'(frame_ok), 64'(f[4]));
                    check("err", 64'(err), 64'(f[3:0]));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst   = 1'b0;
        rxd   = 4'h0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hdr_valid",  64'(hdr_valid),  64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout",       64'(dout),       64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_ok",   64'(frame_ok),   64'd0);
        check("rst_err",        64'(err),        64'd0);
        check("rst_mac_src",    64'(mac_src),    64'd0);
        check("rst_ethertype",  64'(ethertype),  64'd0);
        rst = 1'b1;
        gap(3);

        // Unicast good frame, payload 00..2D.
        build(MAC, SRC, 16'h0800, 46, 8'h00);
        expect_out(46, 1, 1, 1'b1, 4'b0000, 16'h0800);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("good");

        // Broadcast with corrupted FCS.
        build(BC, SRC, 16'h86DD, 50, 8'h40);
        fq[fq.size() - 1] = fq[fq.size() - 1] ^ 8'h01;
        expect_out(50, 1, 1, 1'b0, 4'b1000, 16'h86DD);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("crc_bad");

        // Foreign destination is filtered.
        build(48'h02_00_00_00_00_01, SRC, 16'h0800, 46, 8'h10);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("filtered");

        // 40-byte runt with good CRC.
        build(MAC, SRC, 16'h0806, 22, 8'h80);
        expect_out(22, 1, 1, 1'b0, 4'b0100, 16'h0806);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("runt");

        // rx_er during payload byte 10.
        build(MAC, SRC, 16'h0800, 46, 8'hA0);
        expect_out(46, 1, 1, 1'b0, 4'b0001, 16'h0800);
        send_pre();
        send_bytes(0, fq.size(), 14 + 10);
        gap(12);
        check_empty("phy_err");

        // MAX_LEN+1 byte frame: output stops after MAX_LEN-19 payload bytes.
        build(MAC, SRC, 16'h0800, MAXL + 1 - 18, 8'h00);
        expect_out(MAXL - 19, 0, 1, 1'b0, 4'b0010, 16'h0800);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("oversize");

        // Reset mid-payload; the tail carries a fake preamble and our address.
        build(MAC, SRC, 16'h0800, 46, 8'h00);
        fq[44] = 8'h55;
        fq[45] = 8'h55;
        fq[46] = 8'hD5;
        for (int i = 0; i < 6; i++) fq[47 + i] = MAC[(5 - i)*8 +: 8];
        expect_out(15, 0, 0, 1'b0, 4'b0000, 16'h0800);
        send_pre();
        send_bytes(0, 34, -1);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_dout_valid", 64'(dout_valid), 64'd0);
        check("abort_frame_done", 64'(frame_done), 64'd0);
        check("abort_err",        64'(err),        64'd0);
        @(posedge clk);
        #1;
        send_bytes(34, 40, -1);
        rst = 1'b1;
        send_bytes(40, fq.size(), -1);
        gap(12);
        check_empty("abort");

        // Good frame after the abort.
        build(BC, SRC, 16'h88B5, 48, 8'h33);
        expect_out(48, 1, 1, 1'b1, 4'b0000, 16'h88B5);
        send_pre();
        send_bytes(0, fq.size(), -1);
        gap(12);
        check_empty("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
